aes_resp_misr: RTL
==================

AES_RESP_MISR -- requirements
Module: aes_resp_misr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the width of the response word and signature.
REQ-002 The block SHALL have parameter LATENCY, default 21, giving the cycles from start to the first valid response word; legal range 1..255.
REQ-003 The block SHALL have parameter SEED, default 0 (WIDTH bits), giving the initial signature value.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port start, input, 1 bit: single-cycle request to begin a capture run.
REQ-007 Port num_tests, input, 32 bits: number of response words to compact; sampled only when start is accepted.
REQ-008 Port data_in, input, WIDTH bits: the response word (AES ciphertext) to be compacted.
REQ-009 Port expected, input, WIDTH bits: golden signature; compared combinationally while in DONE.
REQ-010 Port busy, output, 1 bit: high in WAIT and COMPACT.
REQ-011 Port done, output, 1 bit: high in DONE.
REQ-012 Port pass, output, 1 bit: high only in DONE when signature equals expected.
REQ-013 Port signature, output, WIDTH bits: current MISR contents.
REQ-014 Port words_left, output, 32 bits: response words still to be compacted.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, COMPACT and DONE.
REQ-016 start SHALL be accepted in IDLE or DONE on a cycle t; on acceptance: signature <= SEED, words_left <= num_tests, and latency counter <= LATENCY-1.
REQ-017 If num_tests == 0 at acceptance, the next state SHALL be DONE; otherwise it SHALL be WAIT.
REQ-018 WAIT SHALL decrement the latency counter each cycle and move to COMPACT when the counter is 0, so that the first compacted sample is data_in at cycle t+LATENCY.
REQ-019 Each COMPACT cycle SHALL update signature <= {signature[WIDTH-2:0], fb} XOR data_in.
REQ-020 For WIDTH=128, fb SHALL be signature[127] ^ signature[125] ^ signature[100] ^ signature[98]; this is the same polynomial as the stimulus LFSR.
REQ-021 Each COMPACT cycle SHALL decrement words_left; when words_left == 1 the state SHALL move to DONE.
REQ-022 Exactly num_tests words SHALL be sampled, on cycles t+LATENCY .. t+LATENCY+num_tests-1.
REQ-023 done SHALL first be high on cycle t+LATENCY+num_tests.
REQ-024 DONE SHALL hold signature stable and remain until reset or a new start.
REQ-025 start in WAIT or COMPACT SHALL be ignored and SHALL have no effect on the run.
REQ-026 words_left SHALL be 32-bit unsigned with no wrap: the 0 case is handled by REQ-017, and num_tests = 2^32-1 SHALL be supported.
REQ-027 data_in SHALL be ignored outside COMPACT.
REQ-028 pass SHALL be 0 in all states other than DONE.

Reset
REQ-029 While rst_n is low at a rising edge: state <= IDLE, signature <= SEED, words_left <= 0, latency counter <= 0.
REQ-030 While in reset, busy, done and pass SHALL all be 0.
REQ-031 Reset asserted in WAIT or COMPACT SHALL abort the run; no partial result SHALL be flagged.
REQ-032 A start on the same cycle as reset SHALL be ignored.

Verification
REQ-033 Zero-length run (SEED=0, num_tests=0, start at t) -> done=1 at t+1, signature=0, pass=1 with expected=0.
REQ-034 Single word (SEED=0, num_tests=1, data_in=128'h1 only at t+21, 0 elsewhere) -> done at t+22, signature=128'h1; expected=128'h1 gives pass=1, expected=128'h0 gives pass=0.
REQ-035 Two words (data_in=128'h1 at t+21, 128'h0 at t+22, num_tests=2) -> done at t+23, signature=128'h2; busy high on t+1..t+22.
REQ-036 Feedback tap check (SEED=128'h8000_0000_0000_0000_0000_0000_0000_0000, num_tests=1, data_in=0) -> signature=128'h1.
REQ-037 Mid-run reset (num_tests=10, rst_n low at t+25) -> next cycle in IDLE with signature=SEED and done=0; an extra start at t+5 during a run leaves done timing unchanged.
REQ-038 Restart from DONE (new start with num_tests=3) -> signature reseeded, done drops the next cycle and rises again 24 cycles after the new start.

Source files
------------

// File: rtl/aes_resp_misr.sv
// Response compactor for the AES self-test: folds a run of ciphertext words
// into a MISR signature and flags pass/fail against a golden value.
module aes_resp_misr #(
  parameter int               WIDTH   = 128,
  parameter int               LATENCY = 21,
  parameter logic [WIDTH-1:0] SEED    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      num_tests,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [31:0]      words_left
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMPACT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [31:0]      wordsLeft_q;
  logic [7:0]       latCnt_q;
  logic             busy_q;
  logic             done_q;
  logic             fb;

  // Taps 127/125/100/98 at WIDTH=128, kept relative to the MSB so they scale.
  assign fb    = sig_q[WIDTH-1] ^ sig_q[WIDTH-3] ^ sig_q[WIDTH-28] ^ sig_q[WIDTH-30];
  assign sig_d = {sig_q[WIDTH-2:0], fb} ^ data_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sig_q       <= SEED;
      wordsLeft_q <= '0;
      latCnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_q       <= SEED;
            wordsLeft_q <= num_tests;
            latCnt_q    <= 8'(LATENCY - 1);
            if (num_tests == 32'd0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (LATENCY == 1) begin
              state_q <= COMPACT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= WAIT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        // Leaving on a count of 1 lands the first COMPACT cycle at start+LATENCY.
        WAIT: begin
          latCnt_q <= latCnt_q - 8'd1;
          if (latCnt_q == 8'd1) begin
            state_q <= COMPACT;
          end
        end
        COMPACT: begin
          sig_q       <= sig_d;
          wordsLeft_q <= wordsLeft_q - 32'd1;
          if (wordsLeft_q == 32'd1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (sig_q == expected);
  assign signature  = sig_q;
  assign words_left = wordsLeft_q;

endmodule
